// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: groups the hazard-detection inputs and the pipeline
// control outputs of hazard_ctrl.
//   slave  modport : used by hazard_ctrl (receives hazard info, drives controls)
//   master modport : used by the pipeline side (drives hazard info, receives controls)
// Signals:
//   IDEX_MemRead, IDEX_Rt           load in EX and its destination register
//   IFID_Rs, IFID_Rt                source registers of the instruction in ID
//   IFID_UsesRs, IFID_UsesRt        ID instruction actually reads Rs / Rt
//   branch_taken                    branch resolved taken in EX
//   mem_busy                        data memory not ready
//   PCWrite, IFIDWrite, IFIDFlush   PC / IF/ID controls
//   IDEXBubble, ExStall             ID/EX bubble and back-end hold
//   stall_count, flush_count        saturating statistics (zero when disabled)
interface hazard_ctrl_if #(
    parameter int REG_W = 2
);
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_Rt;
    logic [REG_W-1:0] IFID_Rs;
    logic [REG_W-1:0] IFID_Rt;
    logic             IFID_UsesRs;
    logic             IFID_UsesRt;
    logic             branch_taken;
    logic             mem_busy;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXBubble;
    logic             ExStall;
    logic [7:0]       stall_count;
    logic [7:0]       flush_count;

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRs, IFID_UsesRt,
               branch_taken, mem_busy,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, ExStall,
               stall_count, flush_count
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRs, IFID_UsesRt,
               branch_taken, mem_busy,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, ExStall,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller. Resolves load-use hazards
// (one-cycle stall), taken-branch penalties (BR_PENALTY flushed cycles) and
// data-memory wait states (full freeze). Priority: reset > mem_busy >
// branch_taken > load-use.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      hazard_ctrl_if.slave (hazard inputs, pipeline control outputs)
// Parameters:
//   REG_W       register index width
//   BR_PENALTY  flushed cycles per taken branch (1..7)
// Optional feature macro: HAZ_STATS_EN builds the saturating stall/flush
// counters; without it stall_count and flush_count read 8'h00.
module hazard_ctrl #(
    parameter int REG_W      = 2,
    parameter int BR_PENALTY = 1
) (
    input logic          clock,
    input logic          reset_n,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam bit         MULTI_FLUSH = (BR_PENALTY > 1);
    localparam logic [2:0] FLUSH_INIT  = 3'(BR_PENALTY - 1);

    state_t           state_r, state_s, eff_state_s;
    logic [2:0]       fcnt_r, fcnt_s;
    logic             ret_flush_r, ret_flush_s;
    logic             lu_s;
    logic [REG_W-1:0] idex_rt_s;
    logic             pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, ex_stall_s;

    assign idex_rt_s = bus.IDEX_Rt;
    assign lu_s = bus.IDEX_MemRead &
                  ((bus.IFID_UsesRs & (idex_rt_s == bus.IFID_Rs)) |
                   (bus.IFID_UsesRt & (idex_rt_s == bus.IFID_Rt)));

    // Leaving MEMWAIT acts as the resumed state in the same cycle (no recovery cycle).
    always_comb begin
        eff_state_s = state_r;
        if (state_r == ST_MEMWAIT) begin
            eff_state_s = ret_flush_r ? ST_FLUSH : ST_RUN;
        end else begin
            eff_state_s = state_r;
        end
    end

    // State register with flush counter and resume flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            fcnt_r      <= 3'd0;
            ret_flush_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            fcnt_r      <= fcnt_s;
            ret_flush_r <= ret_flush_s;
        end
    end

    // Next-state logic; mem_busy overrides everything and holds fcnt.
    always_comb begin
        state_s     = eff_state_s;
        fcnt_s      = fcnt_r;
        ret_flush_s = ret_flush_r;
        if (bus.mem_busy) begin
            state_s     = ST_MEMWAIT;
            ret_flush_s = (eff_state_s == ST_FLUSH);
        end else begin
            ret_flush_s = 1'b0;
            case (eff_state_s)
                ST_FLUSH: begin
                    // branch_taken and lu are ignored: the flushed slots are invalid.
                    if (fcnt_r <= 3'd1) begin
                        state_s = ST_RUN;
                        fcnt_s  = 3'd0;
                    end else begin
                        state_s = ST_FLUSH;
                        fcnt_s  = fcnt_r - 3'd1;
                    end
                end
                ST_RUN: begin
                    // The RUN cycle that sees the branch is itself the first flushed cycle.
                    if (bus.branch_taken && MULTI_FLUSH) begin
                        state_s = ST_FLUSH;
                        fcnt_s  = FLUSH_INIT;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_RUN;
                    fcnt_s  = 3'd0;
                end
            endcase
        end
    end

    // Output logic: combinational from current (effective) state and inputs.
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        ex_stall_s    = 1'b0;
        if (!reset_n) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (bus.mem_busy) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            ex_stall_s    = 1'b1;
        end else if ((eff_state_s == ST_FLUSH) || bus.branch_taken) begin
            // IFIDWrite stays high so the synchronous clear takes effect.
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (lu_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
        end else begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
        end
    end

    assign bus.PCWrite    = pc_write_s;
    assign bus.IFIDWrite  = ifid_write_s;
    assign bus.IFIDFlush  = ifid_flush_s;
    assign bus.IDEXBubble = idex_bubble_s;
    assign bus.ExStall    = ex_stall_s;

`ifdef HAZ_STATS_EN
    logic [7:0] stall_cnt_r, flush_cnt_r;
    logic       stall_inc_s;

    assign stall_inc_s = (state_r == ST_RUN) & lu_s & ~bus.mem_busy;

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= 8'h00;
            flush_cnt_r <= 8'h00;
        end else begin
            if (stall_inc_s && (stall_cnt_r != 8'hFF)) begin
                stall_cnt_r <= stall_cnt_r + 8'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s && (flush_cnt_r != 8'hFF)) begin
                flush_cnt_r <= flush_cnt_r + 8'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.stall_count = stall_cnt_r;
    assign bus.flush_count = flush_cnt_r;
`else
    assign bus.stall_count = 8'h00;
    assign bus.flush_count = 8'h00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with BR_PENALTY=3.
// Inputs are driven 1 time unit after each rising edge and outputs sampled
// 1 unit later, well away from the active edge.
module tb_hazard_ctrl;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_ctrl_if #(.REG_W(2)) hif ();

    hazard_ctrl #(.REG_W(2), .BR_PENALTY(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (hif)
    );

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, ExStall}
    wire [4:0] ctl = {hif.PCWrite, hif.IFIDWrite, hif.IFIDFlush, hif.IDEXBubble, hif.ExStall};

    localparam logic [4:0] RUN_O   = 5'b11000;
    localparam logic [4:0] STALL_O = 5'b00010;
    localparam logic [4:0] FLUSH_O = 5'b11110;
    localparam logic [4:0] FRZ_O   = 5'b00001;
    localparam logic [4:0] RST_O   = 5'b00110;

`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] exp_cnt(input int v);
        if (!STATS) return 8'h00;
        else if (v > 255) return 8'hFF;
        else return 8'(v);
    endfunction

    task automatic idle();
        hif.IDEX_MemRead = 1'b0;
        hif.IDEX_Rt      = 2'd0;
        hif.IFID_Rs      = 2'd0;
        hif.IFID_Rt      = 2'd0;
        hif.IFID_UsesRs  = 1'b0;
        hif.IFID_UsesRt  = 1'b0;
        hif.branch_taken = 1'b0;
        hif.mem_busy     = 1'b0;
    endtask

    task automatic set_lu();
        hif.IDEX_MemRead = 1'b1;
        hif.IDEX_Rt      = 2'd2;
        hif.IFID_Rs      = 2'd2;
        hif.IFID_UsesRs  = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (ctl !== RST_O) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d ctl=%b exp=%b", i, ctl, RST_O);
            end
        end
        checks++;
        if (hif.stall_count !== 8'h00 || hif.flush_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_counters stall=%h flush=%h exp=00/00", hif.stall_count, hif.flush_count);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL reset_release ctl=%b exp=%b", ctl, RUN_O);
        end
    endtask

    task automatic test_load_use();
        tick();
        set_lu();
        #1;
        checks++;
        if (ctl !== STALL_O) begin
            errors++;
            $display("FAIL lu_rs_stall ctl=%b exp=%b", ctl, STALL_O);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL lu_release ctl=%b exp=%b", ctl, RUN_O);
        end
        checks++;
        if (hif.stall_count !== exp_cnt(1)) begin
            errors++;
            $display("FAIL lu_stall_count got=%h exp=%h", hif.stall_count, exp_cnt(1));
        end
        tick();
        set_lu();
        hif.IFID_UsesRs = 1'b0;
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL lu_unused_rs ctl=%b exp=%b", ctl, RUN_O);
        end
        tick();
        idle();
        hif.IDEX_MemRead = 1'b1;
        hif.IDEX_Rt      = 2'd3;
        hif.IFID_Rs      = 2'd1;
        hif.IFID_Rt      = 2'd3;
        hif.IFID_UsesRs  = 1'b1;
        hif.IFID_UsesRt  = 1'b1;
        #1;
        checks++;
        if (ctl !== STALL_O) begin
            errors++;
            $display("FAIL lu_rt_stall ctl=%b exp=%b", ctl, STALL_O);
        end
        tick();
        hif.IDEX_MemRead = 1'b0;
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL lu_no_load ctl=%b exp=%b", ctl, RUN_O);
        end
        checks++;
        if (hif.stall_count !== exp_cnt(2)) begin
            errors++;
            $display("FAIL lu_stall_count2 got=%h exp=%h", hif.stall_count, exp_cnt(2));
        end
        idle();
    endtask

    task automatic test_branch();
        tick();
        hif.branch_taken = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== FLUSH_O) begin
                errors++;
                $display("FAIL branch_flush cycle %0d ctl=%b exp=%b", i, ctl, FLUSH_O);
            end
            tick();
            // Re-present a branch during flush cycle 2; it must be ignored.
            hif.branch_taken = (i == 0);
            #1;
        end
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL branch_end ctl=%b exp=%b", ctl, RUN_O);
        end
        checks++;
        if (hif.flush_count !== exp_cnt(3)) begin
            errors++;
            $display("FAIL branch_flush_count got=%h exp=%h", hif.flush_count, exp_cnt(3));
        end
    endtask

    task automatic test_memwait_in_flush();
        tick();
        hif.branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== FLUSH_O) begin
            errors++;
            $display("FAIL mw_first_flush ctl=%b exp=%b", ctl, FLUSH_O);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            hif.branch_taken = 1'b0;
            hif.mem_busy     = 1'b1;
            #1;
            checks++;
            if (ctl !== FRZ_O) begin
                errors++;
                $display("FAIL mw_freeze cycle %0d ctl=%b exp=%b", i, ctl, FRZ_O);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            hif.mem_busy = 1'b0;
            #1;
            checks++;
            if (ctl !== FLUSH_O) begin
                errors++;
                $display("FAIL mw_resume_flush cycle %0d ctl=%b exp=%b", i, ctl, FLUSH_O);
            end
        end
        tick();
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL mw_end ctl=%b exp=%b", ctl, RUN_O);
        end
        checks++;
        if (hif.flush_count !== exp_cnt(6)) begin
            errors++;
            $display("FAIL mw_flush_count got=%h exp=%h", hif.flush_count, exp_cnt(6));
        end
    endtask

    task automatic test_priority();
        tick();
        set_lu();
        hif.branch_taken = 1'b1;
        hif.mem_busy     = 1'b1;
        #1;
        checks++;
        if (ctl !== FRZ_O) begin
            errors++;
            $display("FAIL prio_freeze ctl=%b exp=%b", ctl, FRZ_O);
        end
        tick();
        hif.mem_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== FLUSH_O) begin
            errors++;
            $display("FAIL prio_branch_after_wait ctl=%b exp=%b", ctl, FLUSH_O);
        end
        tick();
        idle();
        #1;
        tick();
        #1;
        checks++;
        if (ctl !== FLUSH_O) begin
            errors++;
            $display("FAIL prio_third_flush ctl=%b exp=%b", ctl, FLUSH_O);
        end
        tick();
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL prio_end ctl=%b exp=%b", ctl, RUN_O);
        end
        checks++;
        if (hif.stall_count !== exp_cnt(2) || hif.flush_count !== exp_cnt(9)) begin
            errors++;
            $display("FAIL prio_counts stall=%h flush=%h exp=%h/%h",
                     hif.stall_count, hif.flush_count, exp_cnt(2), exp_cnt(9));
        end
    endtask

    task automatic test_reset_abort();
        tick();
        hif.branch_taken = 1'b1;
        #1;
        tick();
        hif.branch_taken = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctl !== RST_O || hif.flush_count !== 8'h00) begin
            errors++;
            $display("FAIL abort_flush_reset ctl=%b flush=%h exp=%b/00", ctl, hif.flush_count, RST_O);
        end
        tick();
        reset_n = 1'b1;
        #1;
        tick();
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL abort_flush_no_resume ctl=%b exp=%b", ctl, RUN_O);
        end
        hif.mem_busy = 1'b1;
        tick();
        #1;
        tick();
        hif.mem_busy = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctl !== RST_O) begin
            errors++;
            $display("FAIL abort_memwait_reset ctl=%b exp=%b", ctl, RST_O);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (ctl !== RUN_O) begin
            errors++;
            $display("FAIL abort_memwait_release ctl=%b exp=%b", ctl, RUN_O);
        end
    endtask

    task automatic test_saturation();
        set_lu();
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        #1;
        checks++;
        if (ctl !== STALL_O) begin
            errors++;
            $display("FAIL sat_stall_out ctl=%b exp=%b", ctl, STALL_O);
        end
        idle();
        tick();
        #1;
        checks++;
        if (hif.stall_count !== exp_cnt(300)) begin
            errors++;
            $display("FAIL sat_stall_count got=%h exp=%h", hif.stall_count, exp_cnt(300));
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (hif.stall_count !== 8'h00) begin
            errors++;
            $display("FAIL sat_reset_clear got=%h exp=00", hif.stall_count);
        end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_memwait_in_flush();
        test_priority();
        test_reset_abort();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
